// File: rtl/rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_pkg
// Brief    : Shared types and constants for the receive-side frame controller.
//            State enumeration, abort cause codes, default sync marker and the
//            frame checksum helper.
// Config   : RX_CHECKSUM_EN (checksum byte present in the frame)
// Revision : 1.0 - initial release
// ============================================================================
package rx_frame_pkg;

  // Frame controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_CMD = 3'd1,
    S_DH  = 3'd2,
    S_DL  = 3'd3,
    S_CHK = 3'd4
  } rx_state_e;

  // Abort cause codes reported on Err_Code
  localparam logic [1:0] ERR_PARITY   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  // Frame start marker
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // 8-bit checksum of the payload, carry discarded
  function automatic logic [7:0] calc_checksum(input logic [7:0] cmd,
                                               input logic [7:0] data_h,
                                               input logic [7:0] data_l);
    return cmd + data_h + data_l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : rx_byte_timer
// Brief    : Inter-byte timeout counter. Clears on request, counts while
//            enabled, and flags expiry when the count sits at the last
//            allowed value.
// Config   : none (used by rx_frame_ctrl, see RX_CHECKSUM_EN there)
// Revision : 1.0 - initial release
// ============================================================================
module rx_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  // Counter: clear wins over enable so a byte arriving on the expiry cycle resets it
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_ctrl
// Brief    : Receive frame controller. Hunts for the sync byte, assembles
//            SYNC/CMD/DATA_H/DATA_L[/CHK] frames, enforces an inter-byte
//            timeout and reports good frames and coded aborts as one-cycle
//            strobes.
// Config   : RX_CHECKSUM_EN - when defined the frame carries a trailing
//            checksum byte and checksum aborts (code 3) become possible.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         TO_W           = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Ready,
  input  logic        Rx_Parity_ERR,
  output logic [7:0]  Cmd,
  output logic [15:0] Value,
  output logic        Frame_Valid,
  output logic        Frame_ERR,
  output logic [1:0]  Err_Code,
  output logic [7:0]  Err_Count,
  output logic        Busy
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_CMD  = S_CMD;
  localparam logic [2:0] ST_DH   = S_DH;
  localparam logic [2:0] ST_DL   = S_DL;
`ifdef RX_CHECKSUM_EN
  localparam logic [2:0] ST_CHK  = S_CHK;
`endif

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic        ready_q;
  logic        byte_evt;
  logic        good_byte;
  logic [7:0]  cmd_buf;
  logic [7:0]  dh_buf;
`ifdef RX_CHECKSUM_EN
  logic [7:0]  dl_buf;
  logic [7:0]  chk_sum;
`endif
  logic        timer_clear;
  logic        timer_expire;
  logic        complete;
  logic        abort;
  logic [1:0]  abort_code;
  logic [15:0] new_value;

  // A byte counts once, on the rising edge of the receiver's ready level
  assign byte_evt  = Rx_Ready & ~ready_q;
  assign good_byte = byte_evt & ~Rx_Parity_ERR;
  assign Busy      = (state != ST_IDLE);

`ifdef RX_CHECKSUM_EN
  assign chk_sum = calc_checksum(cmd_buf, dh_buf, dl_buf);
`endif

  // Timer restarts on every byte and is held clear while hunting for sync
  assign timer_clear = byte_evt | (state == ST_IDLE);

  rx_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timer (
    .clk    (CLK),
    .rst    (CLR),
    .clear  (timer_clear),
    .enable (Busy),
    .expire (timer_expire)
  );

  // Next-state decode; parity outranks checksum, a byte outranks the timeout
  always_comb begin
    state_n    = state;
    complete   = 1'b0;
    abort      = 1'b0;
    abort_code = 2'd0;
    new_value  = {dh_buf, Rx_Data};
    case (state)
      ST_IDLE: begin
        if (good_byte && (Rx_Data == SYNC_BYTE)) begin
          state_n = ST_CMD;
        end
      end
      ST_CMD: begin
        if (byte_evt) begin
          if (Rx_Parity_ERR) begin
            abort      = 1'b1;
            abort_code = ERR_PARITY;
          end else begin
            state_n = ST_DH;
          end
        end
      end
      ST_DH: begin
        if (byte_evt) begin
          if (Rx_Parity_ERR) begin
            abort      = 1'b1;
            abort_code = ERR_PARITY;
          end else begin
            state_n = ST_DL;
          end
        end
      end
      ST_DL: begin
        if (byte_evt) begin
          if (Rx_Parity_ERR) begin
            abort      = 1'b1;
            abort_code = ERR_PARITY;
          end else begin
`ifdef RX_CHECKSUM_EN
            state_n = ST_CHK;
`else
            complete = 1'b1;
`endif
          end
        end
      end
`ifdef RX_CHECKSUM_EN
      ST_CHK: begin
        new_value = {dh_buf, dl_buf};
        if (byte_evt) begin
          if (Rx_Parity_ERR) begin
            abort      = 1'b1;
            abort_code = ERR_PARITY;
          end else if (Rx_Data != chk_sum) begin
            abort      = 1'b1;
            abort_code = ERR_CHECKSUM;
          end else begin
            complete = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if ((state != ST_IDLE) && !byte_evt && timer_expire) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end

    if (abort || complete) begin
      state_n = ST_IDLE;
    end
  end

  // State register and ready-level history for edge detection
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= Rx_Ready;
    end
  end

  // Payload capture as each field arrives
  always_ff @(posedge CLK) begin
    if (CLR) begin
      cmd_buf <= '0;
      dh_buf  <= '0;
`ifdef RX_CHECKSUM_EN
      dl_buf  <= '0;
`endif
    end else if (good_byte) begin
      if (state == ST_CMD) begin
        cmd_buf <= Rx_Data;
      end
      if (state == ST_DH) begin
        dh_buf <= Rx_Data;
      end
`ifdef RX_CHECKSUM_EN
      if (state == ST_DL) begin
        dl_buf <= Rx_Data;
      end
`endif
    end
  end

  // Result outputs, strobes and saturating abort counter
  always_ff @(posedge CLK) begin
    if (CLR) begin
      Cmd         <= '0;
      Value       <= '0;
      Frame_Valid <= 1'b0;
      Frame_ERR   <= 1'b0;
      Err_Code    <= '0;
      Err_Count   <= '0;
    end else begin
      Frame_Valid <= complete;
      Frame_ERR   <= abort;
      if (complete) begin
        Cmd   <= cmd_buf;
        Value <= new_value;
      end
      if (abort) begin
        Err_Code <= abort_code;
        if (Err_Count != 8'hFF) begin
          Err_Count <= Err_Count + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
